i2c_scl_gen: RTL and testbench

- Parametrised successor to the I2C SCK generator.
- Produces a 50% duty-cycle SCL from a programmable prescaler.
- Adds an idle-high bus level, an enable/busy handshake, and edge and mid-phase strobes for the SDA shifter.
- Optionally supports slave clock stretching.
- Sits between the register block (prescaler fields) and the I2C byte/bit controller.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_sync2.sv | 21 ++
 rtl/i2c_scl_gen.sv | 140 ++++++++++++++
 tb/tb_i2c_scl_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state type, counter sizing and half-period helper for the I2C clock blocks
package i2c_pkg;

  localparam int I2C_CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } scl_state_t;

  // Half-period in clk cycles: (sppr + 1) << (spr + 1), never less than 2
  function automatic logic [I2C_CNT_W-1:0] half_period(
    input logic [I2C_CNT_W-1:0] sppr,
    input logic [I2C_CNT_W-1:0] spr
  );
    logic [I2C_CNT_W-1:0] mult;
    mult = sppr + 1'b1;
    return mult << (spr + 1'b1);
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// rtl/i2c_sync2.sv - generic two-flop synchroniser, resets to 1 (idle-high bus level)
module i2c_sync2 (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic q_out
);

  logic meta;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      meta  <= 1'b1;
      q_out <= 1'b1;
    end else begin
      meta  <= d_in;
      q_out <= meta;
    end
  end

endmodule

// File: rtl/i2c_scl_gen.sv
// rtl/i2c_scl_gen.sv - 50% duty SCL generator with edge and mid-phase strobes
// Optional slave clock stretching is compiled in with macro SCL_STRETCH_EN.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3,
  parameter int CNT_W  = I2C_CNT_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable_in,
  input  logic [SPPR_W-1:0] sppr_in,
  input  logic [SPR_W-1:0]  spr_in,
  input  logic              scl_in,
  output logic              scl_out,
  output logic              busy_out,
  output logic              fall_stb_out,
  output logic              rise_stb_out,
  output logic              drive_stb_out,
  output logic              sample_stb_out,
  output logic              stretch_out
);

  scl_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] h_lat, h_nxt, h_calc, h_half, h_last;
  logic             scl_nxt, busy_nxt, fall_nxt, rise_nxt;
  logic             drive_nxt, sample_nxt, stretch_nxt;
  logic             hold;

  assign h_calc  = CNT_W'(half_period(I2C_CNT_W'(sppr_in), I2C_CNT_W'(spr_in)));
  assign h_half  = h_lat >> 1;
  assign h_last  = h_lat - 1'b1;
  assign cnt_inc = cnt + 1'b1;

`ifdef SCL_STRETCH_EN
  logic scl_sync;

  i2c_sync2 u_scl_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (scl_in),
    .q_out  (scl_sync)
  );

  // The first two HIGH cycles are blind: the synchroniser still shows the old low level
  assign hold = (state == HIGH) && !scl_sync && (cnt >= CNT_W'(2));
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign hold       = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    h_nxt       = h_lat;
    scl_nxt     = scl_out;
    fall_nxt    = 1'b0;
    rise_nxt    = 1'b0;
    drive_nxt   = 1'b0;
    sample_nxt  = 1'b0;
    stretch_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable_in) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          h_nxt     = h_calc;
          scl_nxt   = 1'b0;
          fall_nxt  = 1'b1;
        end
      end
      LOW: begin
        if (cnt == h_last) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          h_nxt     = h_calc;
          scl_nxt   = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt_inc;
          drive_nxt = (cnt_inc == h_half);
        end
      end
      HIGH: begin
        if (hold) begin
          stretch_nxt = 1'b1;
        end else if (cnt == h_last) begin
          cnt_nxt = '0;
          if (enable_in) begin
            state_nxt = LOW;
            h_nxt     = h_calc;
            scl_nxt   = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt    = cnt_inc;
          sample_nxt = (cnt_inc == h_half);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        scl_nxt   = 1'b1;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      cnt            <= '0;
      h_lat          <= CNT_W'(2);
      scl_out        <= 1'b1;
      busy_out       <= 1'b0;
      fall_stb_out   <= 1'b0;
      rise_stb_out   <= 1'b0;
      drive_stb_out  <= 1'b0;
      sample_stb_out <= 1'b0;
      stretch_out    <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      h_lat          <= h_nxt;
      scl_out        <= scl_nxt;
      busy_out       <= busy_nxt;
      fall_stb_out   <= fall_nxt;
      rise_stb_out   <= rise_nxt;
      drive_stb_out  <= drive_nxt;
      sample_stb_out <= sample_nxt;
      stretch_out    <= stretch_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb/tb_i2c_scl_gen.sv - self-checking bench for i2c_scl_gen (table vectors, corner sequences, random vs trace model)
module tb_i2c_scl_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] sppr = 3'd0;
  logic [2:0] spr = 3'd0;
  logic       scl_in = 1'b1;
  logic       scl_out, busy, fall_stb, rise_stb, drive_stb, sample_stb, stretch;

  int vectors = 0;
  int miscompares = 0;
  bit model_on = 1'b1;

  i2c_scl_gen dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .enable_in      (enable),
    .sppr_in        (sppr),
    .spr_in         (spr),
    .scl_in         (scl_in),
    .scl_out        (scl_out),
    .busy_out       (busy),
    .fall_stb_out   (fall_stb),
    .rise_stb_out   (rise_stb),
    .drive_stb_out  (drive_stb),
    .sample_stb_out (sample_stb),
    .stretch_out    (stretch)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected output trace: one record per future clk cycle, built a whole phase at a time
  typedef struct packed {
    logic scl, fall, rise, drive, sample, end_low, end_high;
  } rec_t;
  rec_t exp_q[$];

  function automatic int h_of(input int sp, input int sr);
    return (sp + 1) * (2 ** (sr + 1));
  endfunction

  task automatic push_phase(input bit high, input int h);
    rec_t r;
    for (int k = 0; k < h; k++) begin
      r.scl      = high;
      r.fall     = !high && (k == 0);
      r.rise     = high && (k == 0);
      r.drive    = !high && (k == h / 2);
      r.sample   = high && (k == h / 2);
      r.end_low  = !high && (k == h - 1);
      r.end_high = high && (k == h - 1);
      exp_q.push_back(r);
    end
  endtask

  task automatic model_edge();
    rec_t dropped;
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (enable) push_phase(1'b0, h_of(int'(sppr), int'(spr)));
    end else begin
      if (exp_q[0].end_low) push_phase(1'b1, h_of(int'(sppr), int'(spr)));
      else if (exp_q[0].end_high && enable) push_phase(1'b0, h_of(int'(sppr), int'(spr)));
      dropped = exp_q.pop_front();
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_trace();
    logic [6:0] act, exp;
    act = {scl_out, busy, fall_stb, rise_stb, drive_stb, sample_stb, stretch};
    if (exp_q.size() == 0) exp = 7'b1000000;
    else exp = {exp_q[0].scl, 1'b1, exp_q[0].fall, exp_q[0].rise,
                exp_q[0].drive, exp_q[0].sample, 1'b0};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL trace {scl,busy,fall,rise,drive,sample,stretch}: got %b expected %b at %0t",
               act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (model_on) model_edge();
    #1;
    if (model_on) check_trace();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin step(); n++; end
    check_int(name, int'(busy), 0);
  endtask

  task automatic run_bit(input int sp, input int sr, output int low_len, output int drv_off,
                         output int high_len, output int smp_off);
    int n = 0;
    sppr = 3'(sp); spr = 3'(sr); enable = 1'b1;
    while (!fall_stb && n < 10) begin step(); n++; end
    enable = 1'b0;
    low_len = 0; drv_off = -1;
    while (scl_out == 1'b0 && low_len < 5000) begin
      if (drive_stb) drv_off = low_len;
      low_len++; step();
    end
    high_len = 0; smp_off = -1;
    while (busy && high_len < 5000) begin
      if (sample_stb) smp_off = high_len;
      high_len++; step();
    end
  endtask

  typedef struct {
    int sppr; int spr; int low_len; int drv_off; int high_len; int smp_off;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int ll, dof, hl, sof, n, rises, falls, steps, st_cnt, smp_cnt;
    int exp_high, exp_st;

    tbl[0] = '{0, 0,  2,  1,  2,  1};
    tbl[1] = '{2, 1, 12,  6, 12,  6};
    tbl[2] = '{1, 0,  4,  2,  4,  2};
    tbl[3] = '{0, 2,  8,  4,  8,  4};
    tbl[4] = '{7, 2, 64, 32, 64, 32};
    tbl[5] = '{3, 3, 64, 32, 64, 32};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_scl", int'(scl_out), 1);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_strobes", int'({fall_stb, rise_stb, drive_stb, sample_stb, stretch}), 0);
    rst = 1'b0;
    step();

    // Divisor table: one full bit per entry
    for (int i = 0; i < 6; i++) begin
      run_bit(tbl[i].sppr, tbl[i].spr, ll, dof, hl, sof);
      check_int($sformatf("tbl%0d_low_len", i), ll, tbl[i].low_len);
      check_int($sformatf("tbl%0d_drive_off", i), dof, tbl[i].drv_off);
      check_int($sformatf("tbl%0d_high_len", i), hl, tbl[i].high_len);
      check_int($sformatf("tbl%0d_sample_off", i), sof, tbl[i].smp_off);
    end

    // Minimum divisor, enable held: edge strobes alternate every 2 cycles
    sppr = 3'd0; spr = 3'd0; enable = 1'b1;
    n = 0;
    while (!fall_stb && n < 10) begin step(); n++; end
    falls = 0; rises = 0;
    for (int k = 0; k < 12; k++) begin
      if (fall_stb) begin falls++; check_int("min_fall_phase", k % 4, 0); end
      if (rise_stb) begin rises++; check_int("min_rise_phase", k % 4, 2); end
      step();
    end
    check_int("min_fall_count", falls, 3);
    check_int("min_rise_count", rises, 3);
    enable = 1'b0;
    wait_idle("min_idle");

    // Stop request at LOW cnt 3: the bit completes, then IDLE
    sppr = 3'd2; spr = 3'd1; enable = 1'b1;
    n = 0;
    while (!fall_stb && n < 10) begin step(); n++; end
    repeat (3) step();
    enable = 1'b0;
    rises = 0; falls = 0; steps = 0;
    while (busy && steps < 200) begin
      step(); steps++;
      if (rise_stb) rises++;
      if (fall_stb) falls++;
    end
    check_int("stop_steps_to_idle", steps, 21);
    check_int("stop_rises", rises, 1);
    check_int("stop_falls", falls, 0);
    repeat (4) step();
    check_int("stop_scl_high", int'(scl_out), 1);

    // Live reprogramming of spr during HIGH
    sppr = 3'd2; spr = 3'd1; enable = 1'b1;
    n = 0;
    while (!rise_stb && n < 100) begin step(); n++; end
    hl = 0;
    while (!fall_stb && hl < 200) begin
      if (hl == 2) spr = 3'd2;
      hl++; step();
    end
    enable = 1'b0;
    ll = 0;
    while (scl_out == 1'b0 && ll < 200) begin ll++; step(); end
    check_int("reprog_high_len", hl, 12);
    check_int("reprog_low_len", ll, 24);
    wait_idle("reprog_idle");

    // Asynchronous reset mid-HIGH
    sppr = 3'd2; spr = 3'd1; enable = 1'b1;
    n = 0;
    while (!rise_stb && n < 100) begin step(); n++; end
    repeat (3) step();
    check_int("pre_reset_scl", int'(scl_out), 1);
    check_int("pre_reset_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_int("midhigh_reset_scl", int'(scl_out), 1);
    check_int("midhigh_reset_busy", int'(busy), 0);
    check_int("midhigh_reset_strobes", int'({fall_stb, rise_stb, drive_stb, sample_stb, stretch}), 0);
    enable = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();

    // Slave stretch: scl_in low for 20 cycles from HIGH cnt 3
`ifdef SCL_STRETCH_EN
    exp_high = 32; exp_st = 20;
`else
    exp_high = 12; exp_st = 0;
`endif
    model_on = 1'b0;
    sppr = 3'd2; spr = 3'd1; enable = 1'b1;
    n = 0;
    while (!rise_stb && n < 100) begin step(); n++; end
    hl = 0; st_cnt = 0; smp_cnt = 0;
    while (!fall_stb && hl < 200) begin
      if (hl == 3) scl_in = 1'b0;
      if (hl == 23) scl_in = 1'b1;
      if (stretch) st_cnt++;
      if (sample_stb) smp_cnt++;
      hl++; step();
    end
    scl_in = 1'b1;
    enable = 1'b0;
    check_int("stretch_high_len", hl, exp_high);
    check_int("stretch_out_cycles", st_cnt, exp_st);
    check_int("stretch_sample_count", smp_cnt, 1);
    wait_idle("stretch_idle");
    exp_q.delete();
    model_on = 1'b1;

    // Randomised run against the trace model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) sppr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) spr = 3'($urandom_range(0, 2));
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
